// File: rtl/din_conditioner.sv
// din_conditioner: synchronises and debounces a raw asynchronous input into a clean level
// with one-cycle rise/fall pulses. Define DIN_COND_SYNC3_EN for a three-flop synchroniser.
module din_conditioner #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  logic             w_obs;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_q;
  logic             r_rise;
  logic             r_fall;
  logic             w_q_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // Synchroniser chain; only the last stage is observed by the debouncer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d_i;
      r_s2 <= r_s1;
    end
  end

`ifdef DIN_COND_SYNC3_EN
  logic r_s3;

  // Optional third stage for extra MTBF margin.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s3 <= 1'b0;
    end else begin
      r_s3 <= r_s2;
    end
  end

  assign w_obs = r_s3;
`else
  assign w_obs = r_s2;
`endif

  // Debounce state, stability counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Next-state: a WAIT state reverts on any sample matching the current level.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      IDLE_LO: begin
        if (w_obs) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!w_obs) begin
          w_state_nxt = IDLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_HI;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!w_obs) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (w_obs) begin
          w_state_nxt = IDLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_LO;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE_LO;
        w_cnt_nxt   = '0;
        w_q_nxt     = 1'b0;
      end
    endcase
  end

  assign q_o    = r_q;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// File: tb/tb_din_conditioner.sv
// Scoreboard bench for din_conditioner: the driver queues expected pulses with their
// edge number, a negedge monitor pops and compares every pulse the DUT emits.
module tb_din_conditioner;

  localparam int STABLE = 4;
`ifdef DIN_COND_SYNC3_EN
  localparam int LAT = STABLE + 2;
`else
  localparam int LAT = STABLE + 1;
`endif

  typedef struct {
    int rise;
    int edge_n;
  } ev_t;

  logic clk;
  logic reset_n;
  logic d_i;
  logic q_o;
  logic rise_o;
  logic fall_o;

  ev_t  exp_q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   k;

  din_conditioner #(.STABLE_CYCLES(STABLE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (d_i),
    .q_o     (q_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int r, input int e);
    ev_t ev;
    ev.rise   = r;
    ev.edge_n = e;
    exp_q.push_back(ev);
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    ev_t ev;
    if (rise_o === 1'b1 || fall_o === 1'b1) begin
      chk("both_pulses", int'(rise_o & fall_o), 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got rise=%0b fall=%0b at edge %0d, expected none",
                 rise_o, fall_o, cyc);
      end else begin
        ev = exp_q.pop_front();
        chk("pulse_kind", int'(rise_o), ev.rise);
        chk("pulse_edge", cyc, ev.edge_n);
        chk("q_at_pulse", int'(q_o), ev.rise);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    d_i     = 1'b1;

    // Scenario 1: reset with d_i high, then debounce to 1
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_q", int'(q_o), 0);
      chk("reset_rise", int'(rise_o), 0);
      chk("reset_fall", int'(fall_o), 0);
    end
    reset_n = 1'b1;
    expect_ev(1, cyc + 1 + LAT);
    cyc_wait(LAT + 4);
    chk("post_reset_q", int'(q_o), 1);

    // Clean fall
    d_i = 1'b0;
    expect_ev(0, cyc + 1 + LAT);
    cyc_wait(LAT + 4);
    chk("clean_fall_q", int'(q_o), 0);

    // Scenario 3: three-cycle glitch is rejected
    d_i = 1'b1;
    cyc_wait(3);
    d_i = 1'b0;
    cyc_wait(LAT + 6);
    chk("glitch_q", int'(q_o), 0);
    chk("glitch_no_pending", exp_q.size(), 0);

    // Four-cycle pulse is the shortest accepted; fall follows back-to-back
    d_i = 1'b1;
    k   = cyc + 1;
    expect_ev(1, k + LAT);
    cyc_wait(4);
    d_i = 1'b0;
    expect_ev(0, k + 4 + LAT);
    cyc_wait(LAT + 8);
    chk("min_pulse_q", int'(q_o), 0);

    // Scenario 2: clean rise then return low
    d_i = 1'b1;
    expect_ev(1, cyc + 1 + LAT);
    cyc_wait(LAT + 4);
    chk("clean_rise_q", int'(q_o), 1);
    d_i = 1'b0;
    expect_ev(0, cyc + 1 + LAT);
    cyc_wait(LAT + 4);

    // Scenario 4: bounce 1,0,1,0,1 then settle high
    k   = cyc + 1;
    d_i = 1'b1; cyc_wait(1);
    d_i = 1'b0; cyc_wait(1);
    d_i = 1'b1; cyc_wait(1);
    d_i = 1'b0; cyc_wait(1);
    d_i = 1'b1;
    expect_ev(1, k + 4 + LAT);
    cyc_wait(LAT + 4);
    chk("bounce_q", int'(q_o), 1);
    d_i = 1'b0;
    expect_ev(0, cyc + 1 + LAT);
    cyc_wait(LAT + 4);

    // Scenario 5: reset asserted mid-wait aborts it
    d_i = 1'b1;
    cyc_wait(3);
    reset_n = 1'b0;
    cyc_wait(1);
    chk("midwait_rst_q", int'(q_o), 0);
    chk("midwait_rst_rise", int'(rise_o), 0);
    cyc_wait(1);
    chk("midwait_rst_q2", int'(q_o), 0);
    reset_n = 1'b1;
    expect_ev(1, cyc + 1 + LAT);
    cyc_wait(LAT + 4);
    chk("midwait_after_q", int'(q_o), 1);

    cyc_wait(2);
    chk("missing_pulses", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/din_conditioner.md
# din_conditioner

- Input conditioning stage directly upstream of the team's D-flop register stage.
- Takes a raw, asynchronous, possibly bouncing single-bit input and synchronises it into `clk` through a two-flop synchroniser.
- Debounces it with a stability counter and FSM, then drives a clean level plus one-cycle rise/fall pulses.
- `q_o` connects directly to the register stage's `d_i`.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronised samples that must differ from `q_o` before `q_o` toggles. Legal range 2..255.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: counter width. Do not override.
- `clk`  input  1  single clock; all state updates on posedge.
- `reset_n`  input  1  synchronous, active-low reset, sampled on posedge `clk`.
- `d_i`  input  1  raw asynchronous input; no timing relation to `clk`.
- `q_o`  output  1  debounced, synchronised level; registered.
- `rise_o`  output  1  one-cycle pulse on the cycle `q_o` goes 0→1; registered.
- `fall_o`  output  1  one-cycle pulse on the cycle `q_o` goes 1→0; registered.

## Operation
**Synchroniser**
- `s1 <= d_i`, `s2 <= s1`.
- Only `s2` is used downstream. No logic on `s1`.

**FSM states**
- IDLE_LO: `q_o`=0.
- WAIT_HI: `q_o`=0, candidate 1.
- IDLE_HI: `q_o`=1.
- WAIT_LO: `q_o`=1, candidate 0.

**Transitions, evaluated each posedge with `reset_n`=1**
- IDLE_LO, `s2`=1 → WAIT_HI, `cnt`<=1.
- IDLE_HI, `s2`=0 → WAIT_LO, `cnt`<=1.
- WAIT_x, `s2` equals the candidate, `cnt`<STABLE_CYCLES-1 → stay, `cnt`<=`cnt`+1.
- WAIT_x, `s2` equals the candidate, `cnt`==STABLE_CYCLES-1 → move to the IDLE state of the candidate and `cnt`<=0.
  - `q_o` toggles on this edge.
  - `rise_o` or `fall_o` is 1 for exactly this cycle.
- WAIT_x, `s2` reverts to the current `q_o` (a glitch) → back to the prior IDLE, `cnt`<=0, no pulse, `q_o` unchanged.

**Outputs**
- `rise_o` and `fall_o` are never both 1.
- Each is 0 in every cycle other than the toggle cycle.

**Reset**
- With `reset_n`=0 at a posedge: `s1`, `s2`, `q_o`, `rise_o`, `fall_o`, `cnt` all become 0 and the FSM goes to IDLE_LO.
- Reset asserted mid-WAIT aborts the wait with no pulse.
- If `d_i`=1 while in reset, after release the block debounces normally to 1 and emits `rise_o`.

**Counter**
- Saturation is impossible because `cnt` is bounded by STABLE_CYCLES-1.
- Compare with full `CNT_W` width, no truncation.

## Timing
Let edge k be the first posedge at which `s1` captures a new stable `d_i`.
- `s2` holds the new value after edge k+1.
- The FSM enters WAIT at edge k+2.
- `q_o` toggles, and its pulse asserts, at edge k+1+STABLE_CYCLES.
  - Default STABLE_CYCLES=4: edge k+5.
- The pulse deasserts at edge k+2+STABLE_CYCLES.
- A pulse on `d_i` shorter than STABLE_CYCLES clock periods, as seen at `s2`, is fully rejected.
- Back-to-back toggles: a new opposite transition can enter WAIT on the edge immediately after a toggle edge. Minimum spacing between two pulses is STABLE_CYCLES cycles.

## Configuration
- `DIN_COND_SYNC3_EN` defined: a third synchroniser flop `s3` is inserted (`s3 <= s2`) and the FSM observes `s3`.
  - All latencies in Timing grow by +1 cycle: toggle at edge k+2+STABLE_CYCLES.
  - `s3` resets to 0.
- `DIN_COND_SYNC3_EN` undefined: two-flop synchroniser exactly as above.
- Port list is identical in both builds.

## Test plan
Clock period 10, STABLE_CYCLES=4, macro undefined unless stated.

1. **Reset:** hold `reset_n`=0 for 3 edges with `d_i`=1.
   - During reset, `q_o`/`rise_o`/`fall_o`=0.
   - After release, `q_o`=1 with a single `rise_o` pulse at edge k+5.
2. **Clean rise:** `d_i` 0→1 before edge k and held.
   - `q_o`=1 and `rise_o`=1 at edge k+5 only.
   - `rise_o`=0 at k+6.
   - `fall_o` stays 0 throughout.
3. **Glitch reject:** `d_i` high for 3 cycles, then low.
   - `q_o` stays 0; `rise_o`/`fall_o` never assert.
   - FSM returns to IDLE_LO.
4. **Bounce then settle:** `d_i` toggles 1,0,1,0,1 on successive cycles, then holds 1.
   - Exactly one `rise_o`, 5 edges after the final 0→1 capture.
5. **Reset mid-wait:** `d_i`=1 captured at edge k, `reset_n`=0 at edge k+3.
   - No pulse; `q_o`=0 through reset.
   - After release, a rise occurs 5 edges after re-capture.
6. **Three-flop build:** `DIN_COND_SYNC3_EN` defined, repeat scenario 2.
   - `rise_o` at edge k+6.
   - Scenario 3 is still rejected.
